// File: rtl/pcie_wr_burst_pack_pkg.sv
// Shared definitions for the frame-buffer write burst packer.
// Holds the FSM state encoding, the TLP length width, the 4 KB boundary
// constant and the helper that derives the base-address alignment mask.
package pcie_wr_burst_pack_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned TLP_LEN_W   = 10;
    localparam int unsigned BOUNDARY_4K = 4096;

    // Mask that clears the low address bits covering one full burst. Burst
    // bytes are clamped to 4 KB so an aligned burst never straddles a page.
    function automatic logic [31:0] align_mask(input int unsigned burst_len);
        int unsigned bytes;
        bytes = burst_len * 4;
        if (bytes > BOUNDARY_4K) begin
            bytes = BOUNDARY_4K;
        end
        return ~(32'(bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/pcie_wr_burst_pack_if.sv
// Streaming bus bundle for the burst packer.
// Upstream side : fifo_rd_data / fifo_rd_vld (show-ahead FIFO), fifo_rd_en pop.
// Downstream side: tlp_data / tlp_valid / tlp_ready handshake plus burst
//                  framing (tlp_sop, tlp_eop) and header (tlp_addr, tlp_len).
// master: the packer. slave: the FIFO + TLP sink environment.
interface pcie_wr_burst_pack_if #(
    parameter int unsigned DATA_W = 32
);
    import pcie_wr_burst_pack_pkg::*;

    logic [DATA_W-1:0]    fifo_rd_data;
    logic                 fifo_rd_vld;
    logic                 fifo_rd_en;
    logic [DATA_W-1:0]    tlp_data;
    logic                 tlp_valid;
    logic                 tlp_ready;
    logic                 tlp_sop;
    logic                 tlp_eop;
    logic [31:0]          tlp_addr;
    logic [TLP_LEN_W-1:0] tlp_len;

    modport master (
        input  fifo_rd_data, fifo_rd_vld, tlp_ready,
        output fifo_rd_en, tlp_data, tlp_valid, tlp_sop, tlp_eop, tlp_addr, tlp_len
    );

    modport slave (
        output fifo_rd_data, fifo_rd_vld, tlp_ready,
        input  fifo_rd_en, tlp_data, tlp_valid, tlp_sop, tlp_eop, tlp_addr, tlp_len
    );

endinterface

// File: rtl/pcie_wr_burst_pack.sv
// Frame-buffer write burst packer.
// Splits a frame of cfg_frame_words DW starting at cfg_base_addr into bursts
// of at most BURST_LEN DW, passing FIFO data straight through to the TLP side.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_cfg_en            run enable (checked at frame start, burst end, frame end)
//   i_cfg_base_addr     frame byte base (low burst bits forced to 0)
//   i_cfg_frame_words   DW per frame; 0 keeps the block idle
//   io_bus              FIFO read side and TLP stream side (master modport)
//   o_busy              high in every state except idle
//   o_frame_done        one-cycle pulse when a frame completes
//   o_frame_cnt         completed frame count, wraps at 16 bits
module pcie_wr_burst_pack
    import pcie_wr_burst_pack_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned FRAME_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cfg_en,
    input  logic [31:0]          i_cfg_base_addr,
    input  logic [FRAME_W-1:0]   i_cfg_frame_words,
    pcie_wr_burst_pack_if.master io_bus,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [15:0]          o_frame_cnt
);

    localparam logic [31:0]          ADDR_MASK   = align_mask(BURST_LEN);
    localparam logic [TLP_LEN_W-1:0] BURST_LEN_L = TLP_LEN_W'(BURST_LEN);

    state_e               r_state,     w_state_nxt;
    logic [31:0]          r_cur_addr,  w_cur_addr_nxt;
    logic [FRAME_W-1:0]   r_remain,    w_remain_nxt;
    logic [TLP_LEN_W-1:0] r_beat_cnt,  w_beat_cnt_nxt;
    logic [31:0]          r_tlp_addr,  w_tlp_addr_nxt;
    logic [TLP_LEN_W-1:0] r_tlp_len,   w_tlp_len_nxt;
    logic [15:0]          r_frame_cnt, w_frame_cnt_nxt;

    logic                 w_in_data;
    logic                 w_accept;
    logic                 w_eop;
    logic [TLP_LEN_W-1:0] w_burst_len;
    logic [FRAME_W-1:0]   w_remain_left;

    assign w_in_data     = (r_state == StData);
    assign w_accept      = w_in_data && io_bus.fifo_rd_vld && io_bus.tlp_ready;
    assign w_eop         = w_in_data && (r_beat_cnt == (r_tlp_len - TLP_LEN_W'(1)));
    assign w_burst_len   = (32'(r_remain) >= BURST_LEN) ? BURST_LEN_L : TLP_LEN_W'(r_remain);
    assign w_remain_left = r_remain - FRAME_W'(r_tlp_len);

    // Data path is a zero-latency pass-through gated by the DATA state.
    assign io_bus.tlp_valid  = w_in_data && io_bus.fifo_rd_vld;
    assign io_bus.tlp_data   = w_in_data ? io_bus.fifo_rd_data : {DATA_W{1'b0}};
    assign io_bus.fifo_rd_en = w_accept;
    assign io_bus.tlp_sop    = w_in_data && (r_beat_cnt == '0);
    assign io_bus.tlp_eop    = w_eop;
    assign io_bus.tlp_addr   = r_tlp_addr;
    assign io_bus.tlp_len    = r_tlp_len;

    assign o_busy       = (r_state != StIdle);
    assign o_frame_done = (r_state == StDone);
    assign o_frame_cnt  = r_frame_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_addr_nxt  = r_cur_addr;
        w_remain_nxt    = r_remain;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_tlp_addr_nxt  = r_tlp_addr;
        w_tlp_len_nxt   = r_tlp_len;
        w_frame_cnt_nxt = r_frame_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_cfg_en && (i_cfg_frame_words != '0)) begin
                    w_cur_addr_nxt = i_cfg_base_addr & ADDR_MASK;
                    w_remain_nxt   = i_cfg_frame_words;
                    w_state_nxt    = StStart;
                end
            end
            StStart: begin
                w_tlp_len_nxt  = w_burst_len;
                w_tlp_addr_nxt = r_cur_addr;
                w_beat_cnt_nxt = '0;
                w_state_nxt    = StData;
            end
            StData: begin
                if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + TLP_LEN_W'(1);
                    if (w_eop) begin
                        w_cur_addr_nxt = r_cur_addr + 32'({r_tlp_len, 2'b00});
                        w_remain_nxt   = w_remain_left;
                        // A finished frame always reports done; a dropped
                        // enable only stops at a burst boundary mid-frame.
                        if (w_remain_left == '0) begin
                            w_state_nxt = StDone;
                        end else if (!i_cfg_en) begin
                            w_state_nxt = StIdle;
                        end else begin
                            w_state_nxt = StStart;
                        end
                    end
                end
            end
            StDone: begin
                w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                if (i_cfg_en && (i_cfg_frame_words != '0)) begin
                    w_cur_addr_nxt = i_cfg_base_addr & ADDR_MASK;
                    w_remain_nxt   = i_cfg_frame_words;
                    w_state_nxt    = StStart;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cur_addr  <= '0;
            r_remain    <= '0;
            r_beat_cnt  <= '0;
            r_tlp_addr  <= '0;
            r_tlp_len   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_remain    <= w_remain_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_tlp_addr  <= w_tlp_addr_nxt;
            r_tlp_len   <= w_tlp_len_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pcie_wr_burst_pack.sv
// Bench for pcie_wr_burst_pack with default parameters (DATA_W=32,
// BURST_LEN=32, FRAME_W=24). A table of frame configurations is run through a
// common frame driver; cfg_en drop, zero-length frame and mid-burst reset are
// hand-written sequences. The FIFO model presents WORD_BASE + pop index.
module tb_pcie_wr_burst_pack;

    localparam logic [31:0] WORD_BASE = 32'hA500_0000;
    localparam logic [31:0] ALIGN     = 32'hFFFF_FF80;

    typedef struct {
        logic [31:0] base;
        int unsigned words;
        bit          rnd;
        int unsigned frames;
        int unsigned bursts;
        int unsigned last_len;
        logic [31:0] last_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic [31:0] cfg_base_addr;
    logic [23:0] cfg_frame_words;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int unsigned n_cmp;
    int unsigned n_fail;
    int unsigned g_acc;
    int unsigned fifo_ptr;
    int unsigned exp_frames;
    vec_t        vecs [6];

    pcie_wr_burst_pack_if #(.DATA_W(32)) bus ();

    pcie_wr_burst_pack #(
        .DATA_W   (32),
        .BURST_LEN(32),
        .FRAME_W  (24)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cfg_en         (cfg_en),
        .i_cfg_base_addr  (cfg_base_addr),
        .i_cfg_frame_words(cfg_frame_words),
        .io_bus           (bus),
        .o_busy           (busy),
        .o_frame_done     (frame_done),
        .o_frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later. Checks pop
    // against acceptance and data order against the bench's own beat count.
    task automatic drive_cycle(input bit vld, input bit rdy, output bit acc);
        @(negedge clk);
        bus.fifo_rd_vld  = vld;
        bus.tlp_ready    = rdy;
        bus.fifo_rd_data = WORD_BASE + fifo_ptr;
        #1;
        acc = bus.tlp_valid && bus.tlp_ready;
        chk("pop_eq_accept", 32'(bus.fifo_rd_en), 32'(acc));
        if (acc) begin
            chk("data_order", bus.tlp_data, WORD_BASE + g_acc);
            g_acc++;
        end
        if (bus.fifo_rd_en) begin
            fifo_ptr++;
        end
    endtask

    task automatic run_frame(input vec_t v);
        bit          acc;
        bit          vld;
        bit          rdy;
        int unsigned beat;
        int unsigned exp_len;
        int unsigned rem;
        int unsigned frames;
        int unsigned sops;
        int unsigned eops;
        int unsigned cyc;
        logic [31:0] exp_addr;
        logic [31:0] seen_addr;
        logic [9:0]  seen_len;
        exp_addr  = v.base & ALIGN;
        rem       = v.words;
        beat      = 0;
        exp_len   = 0;
        frames    = 0;
        sops      = 0;
        eops      = 0;
        seen_addr = '0;
        seen_len  = '0;
        @(negedge clk);
        cfg_base_addr   = v.base;
        cfg_frame_words = 24'(v.words);
        cfg_en          = 1'b1;
        cyc = 0;
        while (frames < v.frames && cyc < 5000) begin
            vld = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_cycle(vld, rdy, acc);
            cyc++;
            if (acc) begin
                if (beat == 0) begin
                    exp_len = (rem >= 32) ? 32 : rem;
                end
                chk("sop", 32'(bus.tlp_sop), 32'(beat == 0));
                chk("eop", 32'(bus.tlp_eop), 32'(beat == exp_len - 1));
                chk("burst_addr", bus.tlp_addr, exp_addr);
                chk("burst_len", 32'(bus.tlp_len), exp_len);
                if (bus.tlp_sop) begin
                    sops++;
                    seen_addr = bus.tlp_addr;
                    seen_len  = bus.tlp_len;
                end
                if (bus.tlp_eop) begin
                    eops++;
                end
                beat++;
                if (beat == exp_len) begin
                    beat     = 0;
                    exp_addr = exp_addr + 32'(exp_len * 4);
                    rem      = rem - exp_len;
                end
            end
            if (frame_done) begin
                chk("frame_sops", sops, v.bursts);
                chk("frame_eops", eops, v.bursts);
                chk("last_len", 32'(seen_len), v.last_len);
                chk("last_addr", seen_addr, v.last_addr);
                chk("done_at_burst_end", beat, 0);
                frames++;
                exp_frames++;
                if (frames == v.frames) begin
                    cfg_en = 1'b0;
                end
                exp_addr = v.base & ALIGN;
                rem      = v.words;
                sops     = 0;
                eops     = 0;
            end
        end
        chk("frames_seen", frames, v.frames);
        @(negedge clk);
        #1;
        chk("idle_after_frame", 32'(busy), 32'd0);
        chk("frame_done_low", 32'(frame_done), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), exp_frames);
    endtask

    initial begin
        bit          acc;
        int unsigned n;
        int unsigned done_seen;
        bit          started;
        vec_t        vr;

        n_cmp      = 0;
        n_fail     = 0;
        g_acc      = 0;
        fifo_ptr   = 0;
        exp_frames = 0;
        rst_n           = 1'b0;
        cfg_en          = 1'b0;
        cfg_base_addr   = '0;
        cfg_frame_words = '0;
        bus.fifo_rd_vld  = 1'b1;
        bus.tlp_ready    = 1'b1;
        bus.fifo_rd_data = WORD_BASE;

        //             base           words rnd frames bursts last_len last_addr
        vecs[0] = '{32'h1000_0000,  80, 1'b0, 1, 3, 16, 32'h1000_0100};
        vecs[1] = '{32'h1000_0000, 100, 1'b1, 1, 4,  4, 32'h1000_0180};
        vecs[2] = '{32'h2000_0045,  33, 1'b0, 1, 2,  1, 32'h2000_0080};
        vecs[3] = '{32'hFFFF_FF80,  40, 1'b0, 1, 2,  8, 32'h0000_0000};
        vecs[4] = '{32'h0000_0000,   5, 1'b1, 1, 1,  5, 32'h0000_0000};
        vecs[5] = '{32'h3000_0000,  64, 1'b0, 3, 2, 32, 32'h3000_0080};

        // Reset values, with FIFO valid and sink ready held high.
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.tlp_valid), 32'd0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_sop", 32'(bus.tlp_sop), 32'd0);
        chk("rst_eop", 32'(bus.tlp_eop), 32'd0);
        chk("rst_data", bus.tlp_data, 32'd0);
        chk("rst_addr", bus.tlp_addr, 32'd0);
        chk("rst_len", 32'(bus.tlp_len), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end

        // cfg_en dropped after beat 10 of the first burst.
        @(negedge clk);
        cfg_base_addr   = 32'h4000_0000;
        cfg_frame_words = 24'd80;
        cfg_en          = 1'b1;
        n         = 0;
        done_seen = 0;
        started   = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            drive_cycle(1'b1, 1'b1, acc);
            if (acc) begin
                n++;
                if (n == 10) begin
                    cfg_en = 1'b0;
                end
            end
            if (frame_done) begin
                done_seen++;
            end
            if (busy) begin
                started = 1'b1;
            end else if (started) begin
                break;
            end
        end
        chk("drop_en_beats", n, 32);
        chk("drop_en_no_done", done_seen, 0);
        chk("drop_en_idle", 32'(busy), 32'd0);
        chk("drop_en_frame_cnt", 32'(frame_cnt), exp_frames);

        // Zero-length frame never leaves idle.
        cfg_frame_words = 24'd0;
        cfg_en          = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive_cycle(1'b1, 1'b1, acc);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        end
        cfg_en = 1'b0;

        // Reset asserted mid-burst after 5 beats, then a fresh frame.
        vr = '{32'h5000_0000, 64, 1'b0, 1, 2, 32, 32'h5000_0080};
        @(negedge clk);
        cfg_base_addr   = vr.base;
        cfg_frame_words = 24'(vr.words);
        cfg_en          = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
            drive_cycle(1'b1, 1'b1, acc);
            if (acc) begin
                n++;
            end
        end
        chk("pre_reset_beats", n, 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(bus.tlp_valid), 32'd0);
        chk("arst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("arst_sop", 32'(bus.tlp_sop), 32'd0);
        chk("arst_data", bus.tlp_data, 32'd0);
        chk("arst_addr", bus.tlp_addr, 32'd0);
        chk("arst_len", 32'(bus.tlp_len), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_wr_burst_pack.md
PCIE_WR_BURST_PACK -- requirements
Module: pcie_wr_burst_pack

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the payload word width (one DW).
REQ-002 SHALL have parameter BURST_LEN, default 32, meaning the maximum payload DW per burst; power of two, 1..256.
REQ-003 SHALL have parameter FRAME_W, default 24, meaning the width of the frame word counter.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have the configuration ports: cfg_en  in  1  run enable; cfg_base_addr  in  32  frame buffer byte base; cfg_frame_words  in  FRAME_W  DW per frame.
REQ-006 SHALL have the upstream prefetch-FIFO ports: fifo_rd_data  in  DATA_W  show-ahead data; fifo_rd_vld  in  1  data valid; fifo_rd_en  out  1  pop.
REQ-007 SHALL have the downstream ports: tlp_data  out  DATA_W  payload; tlp_valid  out  1; tlp_ready  in  1; tlp_sop  out  1; tlp_eop  out  1; tlp_addr  out  32  burst byte address; tlp_len  out  10  burst DW count.
REQ-008 SHALL have the status ports: busy  out  1; frame_done  out  1  one-cycle pulse; frame_cnt  out  16  completed frames.

Function
REQ-009 SHALL implement the FSM states IDLE, START, DATA and DONE.
REQ-010 IDLE SHALL go to START, loading cur_addr=cfg_base_addr and remain=cfg_frame_words, when cfg_en=1 and cfg_frame_words!=0; otherwise it SHALL stay in IDLE.
REQ-011 START SHALL latch tlp_len=min(BURST_LEN,remain) and tlp_addr=cur_addr, clear beat_cnt and go to DATA; this costs 1 cycle.
REQ-012 In DATA: tlp_valid=fifo_rd_vld; tlp_data=fifo_rd_data; fifo_rd_en=fifo_rd_vld&tlp_ready. All three SHALL be combinational with zero latency.
REQ-013 Outside DATA, tlp_valid and fifo_rd_en SHALL both be 0.
REQ-014 tlp_sop SHALL be (beat_cnt==0) and tlp_eop SHALL be (beat_cnt==tlp_len-1), both qualified by state DATA.
REQ-015 tlp_addr and tlp_len SHALL be stable for the whole burst.
REQ-016 A beat SHALL be accepted only when tlp_valid&tlp_ready; beat_cnt SHALL increment per accepted beat.
REQ-017 fifo_rd_vld low mid-burst SHALL stall the burst with tlp_valid=0; the burst SHALL NOT be aborted and no data SHALL be lost or duplicated.
REQ-018 On an accepted eop: cur_addr+=tlp_len*4 and remain-=tlp_len; the FSM SHALL go to DONE if remain becomes 0, else to START.
REQ-019 DONE SHALL pulse frame_done for 1 cycle and increment frame_cnt, which wraps at 65535->0.
REQ-020 From DONE, the FSM SHALL reload from cfg and go to START if cfg_en=1, else go to IDLE.
REQ-021 cfg_en deasserted mid-frame SHALL let the current burst complete, then go to IDLE without frame_done; there are no truncated bursts.
REQ-022 cfg_* SHALL be sampled only on IDLE->START and on DONE reload; changes at other times SHALL be ignored.
REQ-023 cfg_base_addr bits [log2(BURST_LEN*4)-1:0] SHALL be forced to 0, so no burst crosses a 4 KB boundary.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Address arithmetic SHALL be 32-bit modulo with no saturation.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=IDLE; cur_addr, remain, beat_cnt, tlp_addr, tlp_len and frame_cnt =0; frame_done=0.
REQ-027 During reset, all combinational outputs SHALL be 0 via state IDLE.
REQ-028 Reset mid-burst SHALL drop the partial burst; upstream FIFO contents are the FIFO's own concern.
REQ-029 Release of rst_n SHALL be synchronous to clk, using the codebase's standard reset synchronizer external to this block.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the TLP length width (10) and the 4 KB boundary constant.
REQ-031 There SHALL be no sub-module; the block is a single module with an FSM and three counters.

Verification
REQ-032 BURST_LEN=32, base=0x1000_0000, frame_words=80, FIFO always valid, ready=1 -> bursts len 32/32/16 at 0x1000_0000/0x1000_0080/0x1000_0100; one frame_done; frame_cnt=1.
REQ-033 Random fifo_rd_vld (50%) and random tlp_ready (50%), frame_words=100 -> exactly 100 beats delivered in FIFO order; sop/eop each 4 times; no pop without an accepted beat.
REQ-034 cfg_en held high over 3 frames of 64 -> frame_done at each frame end; address restarts at base each frame; frame_cnt=3.
REQ-035 cfg_en dropped at beat 10 of burst 1 -> burst completes all 32 beats; then busy=0; no frame_done.
REQ-036 rst_n asserted at beat 5 -> all outputs 0 asynchronously; after release with cfg_en=1, a fresh frame starts at base with sop.
REQ-037 cfg_frame_words=0 with cfg_en=1 -> stays IDLE; busy=0; fifo_rd_en never asserted.
